safety_obi_to_reg: RTL and testbench

SAFETY_OBI_TO_REG -- requirements
Module: safety_obi_to_reg

---
 rtl/safety_island_pkg.sv | 25 ++
 rtl/safety_obi_to_reg.sv | 157 +++++++++++++++
 tb/tb_safety_obi_to_reg.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/safety_island_pkg.sv
// Shared constants and register-bus payload types for the safety-island register bridge.
package safety_island_pkg;

  localparam int unsigned RegAddrWidth = 32;
  localparam int unsigned RegDataWidth = 32;
  localparam int unsigned RegStrbWidth = RegDataWidth / 8;

  localparam logic [RegDataWidth-1:0] RegBridgeErrVal         = 32'hBADCAB1E;
  localparam int unsigned             RegBridgeTimeoutDefault = 255;

  typedef struct packed {
    logic [RegAddrWidth-1:0] addr;
    logic                    write;
    logic [RegDataWidth-1:0] wdata;
    logic [RegStrbWidth-1:0] wstrb;
    logic                    valid;
  } reg_req_s;

  typedef struct packed {
    logic [RegDataWidth-1:0] rdata;
    logic                    error;
    logic                    ready;
  } reg_rsp_s;

endpackage

// File: rtl/safety_obi_to_reg.sv
// Single-outstanding OBI-to-register-bus bridge for the safety island.
// Define SAFETY_REG_BRIDGE_TIMEOUT_EN to enable the ready-timeout watchdog.
module safety_obi_to_reg
  import safety_island_pkg::*;
#(
  parameter type         reg_req_t     = logic,
  parameter type         reg_rsp_t     = logic,
  parameter int unsigned TimeoutCycles = RegBridgeTimeoutDefault
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic                    we_i,
  input  logic [RegStrbWidth-1:0] be_i,
  input  logic [RegAddrWidth-1:0] addr_i,
  input  logic [RegDataWidth-1:0] wdata_i,
  output logic                    rvalid_o,
  output logic [RegDataWidth-1:0] rdata_o,
  output logic                    err_o,
  output reg_req_t                reg_req_o,
  input  reg_rsp_t                reg_rsp_i,
  output logic                    timeout_o
);

  if (TimeoutCycles == 0 || TimeoutCycles > 65535) begin : g_bad_timeout
    $error("safety_obi_to_reg: TimeoutCycles must be within 1..65535");
  end

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]              state_q, state_d;
  logic                    we_q, we_d;
  logic [RegStrbWidth-1:0] be_q, be_d;
  logic [RegAddrWidth-1:0] addr_q, addr_d;
  logic [RegDataWidth-1:0] wdata_q, wdata_d;
  logic [RegDataWidth-1:0] rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    tmo_q, tmo_d;
  reg_req_s                req_pkt;
  reg_rsp_s                rsp_pkt;
  logic                    unused_addr_lsb;

`ifdef SAFETY_REG_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  // Peripheral word addressing: the byte offset is carried by the strobes.
  assign unused_addr_lsb = ^addr_i[1:0];
  assign rsp_pkt         = reg_rsp_s'(reg_rsp_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
`ifdef SAFETY_REG_BRIDGE_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
`ifdef SAFETY_REG_BRIDGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic: accept in idle, wait for ready (or watchdog) in busy, pulse in resp.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    gnt_o   = 1'b0;
`ifdef SAFETY_REG_BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        gnt_o = req_i;
        if (req_i) begin
          we_d    = we_i;
          be_d    = be_i;
          addr_d  = {addr_i[RegAddrWidth-1:2], 2'b00};
          wdata_d = wdata_i;
          tmo_d   = 1'b0;
          state_d = StBusy;
`ifdef SAFETY_REG_BRIDGE_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StBusy: begin
        if (rsp_pkt.ready) begin
          rdata_d = we_q ? '0 : rsp_pkt.rdata;
          err_d   = rsp_pkt.error;
          tmo_d   = 1'b0;
          state_d = StResp;
        end
`ifdef SAFETY_REG_BRIDGE_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          rdata_d = RegBridgeErrVal;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Register-bus payload is only driven while a transfer is pending.
  always_comb begin
    req_pkt = '0;
    if (state_q == StBusy) begin
      req_pkt.addr  = addr_q;
      req_pkt.write = we_q;
      req_pkt.wdata = wdata_q;
      req_pkt.wstrb = we_q ? be_q : '0;
      req_pkt.valid = 1'b1;
    end
  end

  assign reg_req_o = reg_req_t'(req_pkt);
  assign rvalid_o  = (state_q == StResp);
  assign rdata_o   = rvalid_o ? rdata_q : '0;
  assign err_o     = rvalid_o & err_q;
`ifdef SAFETY_REG_BRIDGE_TIMEOUT_EN
  assign timeout_o = rvalid_o & tmo_q;
`else
  assign timeout_o = 1'b0 & tmo_q;
`endif

endmodule

// File: tb/tb_safety_obi_to_reg.sv
// Self-checking bench for safety_obi_to_reg: transaction-level model plus directed vectors.
module tb_safety_obi_to_reg;
  import safety_island_pkg::*;

  localparam int unsigned TC = 4;
`ifdef SAFETY_REG_BRIDGE_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, req, we, gnt, rvalid, err, tmo;
  logic [3:0]  be;
  logic [31:0] addr, wdata, rdata;
  reg_req_s    reg_req;
  reg_rsp_s    reg_rsp;

  always #5 clk = ~clk;

  safety_obi_to_reg #(
    .reg_req_t    (reg_req_s),
    .reg_rsp_t    (reg_rsp_s),
    .TimeoutCycles(TC)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .gnt_o    (gnt),
    .we_i     (we),
    .be_i     (be),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .err_o    (err),
    .reg_req_o(reg_req),
    .reg_rsp_i(reg_rsp),
    .timeout_o(tmo)
  );

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral: asserts ready on valid cycle index 'lat' (never when lat < 0).
  int          lat = 0;
  int          vcnt = 0;
  logic [31:0] p_rdata = '0;
  logic        p_err = 1'b0;
  logic        junk_ready = 1'b0;

  always @(posedge clk) begin
    #1;
    if (reg_req.valid) begin
      reg_rsp.ready = (lat >= 0) && (vcnt == lat);
      vcnt++;
    end else begin
      reg_rsp.ready = junk_ready;
      vcnt = 0;
    end
    reg_rsp.rdata = p_rdata;
    reg_rsp.error = p_err;
  end

  // Transaction-level model: an open request waits for ready or the watchdog, then one response cycle.
  bit          chk_en = 1'b0;
  bit          m_open = 1'b0, m_resp = 1'b0, m_tmo = 1'b0, m_we = 1'b0, m_err = 1'b0;
  int          m_wait = 0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

  int          n_rvalid = 0, n_tmo = 0, last_rv_cyc = -1, cur_run = 0, last_run = 0;
  logic [31:0] last_rdata = '0, last_addr = '0, last_wdata = '0;
  logic        last_err = 1'b0;
  logic [3:0]  last_wstrb = '0;
  int          grants[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt",       32'(gnt),            32'((!m_open && !m_resp) ? req : 1'b0));
      check("reg_valid", 32'(reg_req.valid),  32'(m_open));
      check("reg_addr",  reg_req.addr,        m_open ? (m_addr & 32'hFFFF_FFFC) : 32'h0);
      check("reg_write", 32'(reg_req.write),  32'(m_open && m_we));
      check("reg_wdata", reg_req.wdata,       m_open ? m_wdata : 32'h0);
      check("reg_wstrb", 32'(reg_req.wstrb),  32'((m_open && m_we) ? m_be : 4'h0));
      check("rvalid",    32'(rvalid),         32'(m_resp));
      check("rdata",     rdata,               m_resp ? m_rdata : 32'h0);
      check("err",       32'(err),            32'(m_resp && m_err));
      check("timeout",   32'(tmo),            32'(m_resp && m_tmo));
    end
    if (gnt && req) grants.push_back(cyc);
    if (rvalid) begin
      n_rvalid++;
      last_rv_cyc = cyc;
      last_rdata = rdata;
      last_err = err;
      if (tmo) n_tmo++;
    end
    if (reg_req.valid) begin
      cur_run++;
      last_addr = reg_req.addr;
      last_wstrb = reg_req.wstrb;
      last_wdata = reg_req.wdata;
    end else if (cur_run > 0) begin
      last_run = cur_run;
      cur_run = 0;
    end
    if (rst) begin
      m_open = 1'b0;
      m_resp = 1'b0;
      chk_en = 1'b1;
    end else if (m_resp) begin
      m_resp = 1'b0;
    end else if (m_open) begin
      if (reg_rsp.ready) begin
        m_open = 1'b0; m_resp = 1'b1; m_tmo = 1'b0;
        m_rdata = m_we ? 32'h0 : reg_rsp.rdata;
        m_err = reg_rsp.error;
      end else if (TmoEn && m_wait == int'(TC) - 1) begin
        m_open = 1'b0; m_resp = 1'b1; m_tmo = 1'b1;
        m_rdata = 32'hBADCAB1E;
        m_err = 1'b1;
      end else begin
        m_wait++;
      end
    end else if (req) begin
      m_open = 1'b1; m_wait = 0;
      m_we = we; m_be = be; m_addr = addr; m_wdata = wdata;
    end
  end

  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                       output int gc);
    @(posedge clk); #1;
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    gc = -1;
    for (int i = 0; i < 50 && gc < 0; i++) begin
      @(negedge clk);
      if (gnt) gc = cyc;
    end
    if (gc < 0) check("grant_wait_expired", 32'h0, 32'h1);
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int g, n0, t0, gs;
    rst = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    reg_rsp = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_valid", 32'(reg_req.valid), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_timeout", 32'(tmo), 32'h0);

    // Read with ready in the first valid cycle.
    lat = 0; p_rdata = 32'h1234_5678; p_err = 1'b0; n0 = n_rvalid;
    issue(1'b0, 4'hF, 32'h0020_1003, 32'h0, g);
    repeat (4) @(posedge clk); #1;
    check("rd_latency", 32'(last_rv_cyc), 32'(g + 2));
    check("rd_addr", last_addr, 32'h0020_1000);
    check("rd_wstrb", 32'(last_wstrb), 32'h0);
    check("rd_rdata", last_rdata, 32'h1234_5678);
    check("rd_err", 32'(last_err), 32'h0);
    check("rd_count", 32'(n_rvalid), 32'(n0 + 1));

    // Write with ready held low for five cycles.
    lat = 5; p_rdata = 32'h5555_AAAA; n0 = n_rvalid;
    issue(1'b1, 4'b0011, 32'h0000_0104, 32'hCAFE_F00D, g);
    repeat (10) @(posedge clk); #1;
    check("wr_valid_run", 32'(last_run), 32'd6);
    check("wr_wstrb", 32'(last_wstrb), 32'h3);
    check("wr_wdata", last_wdata, 32'hCAFE_F00D);
    check("wr_rdata", last_rdata, 32'h0);
    check("wr_err", 32'(last_err), 32'h0);
    check("wr_latency", 32'(last_rv_cyc), 32'(g + 7));
    check("wr_count", 32'(n_rvalid), 32'(n0 + 1));

    // Peripheral error on a read.
    lat = 2; p_rdata = 32'hDEAD_0001; p_err = 1'b1;
    issue(1'b0, 4'hF, 32'h0000_0040, 32'h0, g);
    repeat (6) @(posedge clk); #1;
    check("perr_err", 32'(last_err), 32'h1);
    check("perr_rdata", last_rdata, 32'hDEAD_0001);
    p_err = 1'b0;

`ifdef SAFETY_REG_BRIDGE_TIMEOUT_EN
    // Watchdog abort, then a late ready that must be ignored.
    lat = -1; n0 = n_rvalid; t0 = n_tmo;
    issue(1'b0, 4'hF, 32'h0000_0200, 32'h0, g);
    repeat (5) @(posedge clk); #1;
    junk_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    junk_ready = 1'b0;
    check("tmo_valid_run", 32'(last_run), 32'd4);
    check("tmo_rdata", last_rdata, 32'hBADCAB1E);
    check("tmo_err", 32'(last_err), 32'h1);
    check("tmo_pulse", 32'(n_tmo), 32'(t0 + 1));
    check("tmo_latency", 32'(last_rv_cyc), 32'(g + 5));
    check("tmo_count", 32'(n_rvalid), 32'(n0 + 1));

    // Ready on the limit cycle completes normally.
    lat = 3; p_rdata = 32'h0000_0ACE; t0 = n_tmo;
    issue(1'b0, 4'hF, 32'h0000_0204, 32'h0, g);
    repeat (6) @(posedge clk); #1;
    check("lim_err", 32'(last_err), 32'h0);
    check("lim_rdata", last_rdata, 32'h0000_0ACE);
    check("lim_no_tmo", 32'(n_tmo), 32'(t0));
`endif

    // Back-to-back requests: req held high for 18 cycles.
    lat = 0; p_rdata = 32'h0000_0077; n0 = n_rvalid; gs = grants.size();
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0000_0080;
    repeat (18) @(posedge clk); #1;
    req = 1'b0; be = '0; addr = '0;
    repeat (5) @(posedge clk); #1;
    check("b2b_grants", 32'(grants.size() - gs), 32'd6);
    check("b2b_resps", 32'(n_rvalid - n0), 32'd6);
    for (int i = gs + 1; i < grants.size(); i++)
      check("b2b_spacing", 32'(grants[i] - grants[i-1]), 32'd3);

    // Reset while busy aborts silently; the next request completes.
    lat = -1; n0 = n_rvalid; t0 = n_tmo;
    issue(1'b0, 4'hF, 32'h0000_0300, 32'h0, g);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstb_valid", 32'(reg_req.valid), 32'h0);
    check("rstb_rvalid", 32'(rvalid), 32'h0);
    repeat (3) @(posedge clk); #1;
    check("rstb_no_resp", 32'(n_rvalid), 32'(n0));
    check("rstb_no_tmo", 32'(n_tmo), 32'(t0));
    lat = 0; p_rdata = 32'h0BAD_F00D;
    issue(1'b0, 4'hF, 32'h0000_0304, 32'h0, g);
    repeat (4) @(posedge clk); #1;
    check("rstb_next_rdata", last_rdata, 32'h0BAD_F00D);
    check("rstb_next_count", 32'(n_rvalid), 32'(n0 + 1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
